// File: rtl/bias_broadcast_core.sv
// Bias broadcast stage: loads a bias vector from V-SRAM into a local buffer,
// then sweeps the M x N C matrix in row-major order. For every element it
// hands C and the selected bias to an external adder and writes the sum to Y.
// Only one memory or adder transaction is in flight at any time.
module bias_broadcast_core #(
    parameter int M       = 8,
    parameter int N       = 8,
    parameter int DATA_W  = 32,
    parameter int ROW_W   = (M <= 1) ? 1 : $clog2(M),
    parameter int COL_W   = (N <= 1) ? 1 : $clog2(N),
    parameter int VADDR_W = (((M > N) ? M : N) <= 1) ? 1 : $clog2((M > N) ? M : N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode_rowcol,
    input  logic               vec_valid,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               v_rd_en,
    output logic [VADDR_W-1:0] v_raddr,
    input  logic [DATA_W-1:0]  v_rdata,
    input  logic               v_rvalid,
    output logic               c_rd_en,
    output logic [ROW_W-1:0]   c_rd_row,
    output logic [COL_W-1:0]   c_rd_col,
    input  logic [DATA_W-1:0]  c_rd_rdata,
    input  logic               c_rd_rvalid,
    output logic               add_req,
    output logic [DATA_W-1:0]  add_a,
    output logic [DATA_W-1:0]  add_b,
    input  logic [DATA_W-1:0]  add_res,
    input  logic               add_rvalid,
    output logic               y_we,
    output logic [ROW_W-1:0]   y_row,
    output logic [COL_W-1:0]   y_col,
    output logic [DATA_W-1:0]  y_wdata
);

    localparam int LEN_MAX = (M > N) ? M : N;
    localparam logic [ROW_W-1:0]   ROW_LAST = ROW_W'(M - 1);
    localparam logic [COL_W-1:0]   COL_LAST = COL_W'(N - 1);
    localparam logic [VADDR_W-1:0] LEN_LAST_ROW = VADDR_W'(N - 1);
    localparam logic [VADDR_W-1:0] LEN_LAST_COL = VADDR_W'(M - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LD_ISSUE = 3'd1,
        LD_WAIT  = 3'd2,
        RD_ISSUE = 3'd3,
        RD_WAIT  = 3'd4,
        ADD_WAIT = 3'd5,
        FINISH   = 3'd6
    } state_t;

    state_t             state_r, state_s;
    logic               mode_r, mode_s;
    logic [VADDR_W-1:0] k_r, k_s;
    logic [ROW_W-1:0]   i_r, i_s;
    logic [COL_W-1:0]   j_r, j_s;
    logic               busy_s, done_s, err_s;
    logic               v_rd_en_s, c_rd_en_s, add_req_s, y_we_s;
    logic [VADDR_W-1:0] v_raddr_s;
    logic [ROW_W-1:0]   c_rd_row_s, y_row_s;
    logic [COL_W-1:0]   c_rd_col_s, y_col_s;
    logic [DATA_W-1:0]  add_a_s, add_b_s, y_wdata_s;
    logic               buf_we_s;
    logic [VADDR_W-1:0] len_last_s;
    logic [VADDR_W-1:0] bias_idx_s;
    logic [DATA_W-1:0]  bias_buf_r [0:LEN_MAX-1];

    // Next-state and next-output computation; pulses default low every cycle.
    always_comb begin
        state_s    = state_r;
        mode_s     = mode_r;
        k_s        = k_r;
        i_s        = i_r;
        j_s        = j_r;
        busy_s     = busy;
        done_s     = 1'b0;
        err_s      = err;
        v_rd_en_s  = 1'b0;
        v_raddr_s  = v_raddr;
        c_rd_en_s  = 1'b0;
        c_rd_row_s = c_rd_row;
        c_rd_col_s = c_rd_col;
        add_req_s  = 1'b0;
        add_a_s    = add_a;
        add_b_s    = add_b;
        y_we_s     = 1'b0;
        y_row_s    = y_row;
        y_col_s    = y_col;
        y_wdata_s  = y_wdata;
        buf_we_s   = 1'b0;
        len_last_s = mode_r ? LEN_LAST_COL : LEN_LAST_ROW;
        bias_idx_s = mode_r ? VADDR_W'(i_r) : VADDR_W'(j_r);

        case (state_r)
            IDLE: begin
                if (start) begin
                    if (vec_valid) begin
                        mode_s  = mode_rowcol;
                        k_s     = '0;
                        i_s     = '0;
                        j_s     = '0;
                        busy_s  = 1'b1;
                        err_s   = 1'b0;
                        state_s = LD_ISSUE;
                    end else begin
                        // No vector to broadcast: flag it and finish without touching memory.
                        err_s   = 1'b1;
                        state_s = FINISH;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            LD_ISSUE: begin
                v_rd_en_s = 1'b1;
                v_raddr_s = k_r;
                state_s   = LD_WAIT;
            end
            LD_WAIT: begin
                if (v_rvalid) begin
                    buf_we_s = 1'b1;
                    if (k_r == len_last_s) begin
                        state_s = RD_ISSUE;
                    end else begin
                        k_s     = k_r + VADDR_W'(1);
                        state_s = LD_ISSUE;
                    end
                end else begin
                    state_s = LD_WAIT;
                end
            end
            RD_ISSUE: begin
                c_rd_en_s  = 1'b1;
                c_rd_row_s = i_r;
                c_rd_col_s = j_r;
                state_s    = RD_WAIT;
            end
            RD_WAIT: begin
                if (c_rd_rvalid) begin
                    add_req_s = 1'b1;
                    add_a_s   = c_rd_rdata;
                    add_b_s   = bias_buf_r[bias_idx_s];
                    state_s   = ADD_WAIT;
                end else begin
                    state_s = RD_WAIT;
                end
            end
            ADD_WAIT: begin
                if (add_rvalid) begin
                    y_we_s    = 1'b1;
                    y_row_s   = i_r;
                    y_col_s   = j_r;
                    y_wdata_s = add_res;
                    if ((i_r == ROW_LAST) && (j_r == COL_LAST)) begin
                        state_s = FINISH;
                    end else if (j_r == COL_LAST) begin
                        j_s     = '0;
                        i_s     = i_r + ROW_W'(1);
                        state_s = RD_ISSUE;
                    end else begin
                        j_s     = j_r + COL_W'(1);
                        state_s = RD_ISSUE;
                    end
                end else begin
                    state_s = ADD_WAIT;
                end
            end
            FINISH: begin
                done_s  = 1'b1;
                busy_s  = 1'b0;
                state_s = IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State, index and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            mode_r   <= 1'b0;
            k_r      <= '0;
            i_r      <= '0;
            j_r      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            v_rd_en  <= 1'b0;
            v_raddr  <= '0;
            c_rd_en  <= 1'b0;
            c_rd_row <= '0;
            c_rd_col <= '0;
            add_req  <= 1'b0;
            add_a    <= '0;
            add_b    <= '0;
            y_we     <= 1'b0;
            y_row    <= '0;
            y_col    <= '0;
            y_wdata  <= '0;
        end else begin
            state_r  <= state_s;
            mode_r   <= mode_s;
            k_r      <= k_s;
            i_r      <= i_s;
            j_r      <= j_s;
            busy     <= busy_s;
            done     <= done_s;
            err      <= err_s;
            v_rd_en  <= v_rd_en_s;
            v_raddr  <= v_raddr_s;
            c_rd_en  <= c_rd_en_s;
            c_rd_row <= c_rd_row_s;
            c_rd_col <= c_rd_col_s;
            add_req  <= add_req_s;
            add_a    <= add_a_s;
            add_b    <= add_b_s;
            y_we     <= y_we_s;
            y_row    <= y_row_s;
            y_col    <= y_col_s;
            y_wdata  <= y_wdata_s;
        end
    end

    // Bias buffer storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (buf_we_s) begin
            bias_buf_r[k_r] <= v_rdata;
        end
    end

endmodule

// File: doc/bias_broadcast_core.md
Name: bias_broadcast_core

Overview:
- Stage directly downstream of the vector slice stage in the EPU bias-adder path.
- Loads the extracted bias vector from V-SRAM into an internal buffer, then sweeps the M×N C matrix in row-major order and adds the bias to every element (FP32 add done by an external adder over a req/resp handshake).
- Writes results through a Y write port; Y may alias C SRAM for in-place update.
- Mode 0 (row bias): bias indexed by column j. Mode 1 (col bias): bias indexed by row i.

Parameters:
- M, 8, matrix rows.
- N, 8, matrix columns.
- DATA_W, 32, element width (FP32 bits).
- ROW_W, (M<=1)?1:$clog2(M), row index width.
- COL_W, (N<=1)?1:$clog2(N), column index width.
- VADDR_W, $clog2(max(M,N)), V-SRAM address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- mode_rowcol  in  1  0=row bias, 1=col bias; sampled on accepted start.
- vec_valid  in  1  V-SRAM holds a valid vector (from the slice stage's v_valid).
- start  in  1  single-cycle request; honoured only in IDLE.
- busy  out  1  high from the cycle after an accepted start until FINISH.
- done  out  1  one-cycle pulse at completion.
- err  out  1  sticky until the next accepted start; set if start arrives with vec_valid=0.
- v_rd_en  out  1  V-SRAM read pulse.
- v_raddr  out  VADDR_W  V-SRAM read address.
- v_rdata  in  DATA_W  V-SRAM read data.
- v_rvalid  in  1  V-SRAM read data valid.
- c_rd_en  out  1  C read pulse.
- c_rd_row  out  ROW_W  C read row.
- c_rd_col  out  COL_W  C read column.
- c_rd_rdata  in  DATA_W  C read data.
- c_rd_rvalid  in  1  C read data valid.
- add_req  out  1  adder request pulse.
- add_a  out  DATA_W  adder operand (C element).
- add_b  out  DATA_W  adder operand (bias).
- add_res  in  DATA_W  adder result.
- add_rvalid  in  1  adder result valid.
- y_we  out  1  result write pulse.
- y_row  out  ROW_W  result row.
- y_col  out  COL_W  result column.
- y_wdata  out  DATA_W  result data.

Behaviour:
- All outputs are registered.
- Reset: state=IDLE. busy, done, err, v_rd_en, c_rd_en, add_req and y_we are 0. Address, data and index registers are 0. Bias buffer contents are don't-care.
- v_rd_en, c_rd_en, add_req, y_we and done default to 0 every cycle, so each assertion is a single-cycle pulse.
- Bias buffer: max(M,N) entries of DATA_W bits. len = N if mode=0, else M.
- State machine:
  - IDLE: on start with vec_valid=1, latch mode, set k=0, i=0, j=0, busy=1, err=0, go to LD_ISSUE. On start with vec_valid=0, set err=1 and go to FINISH with no memory traffic.
  - LD_ISSUE: v_rd_en=1, v_raddr=k, go to LD_WAIT.
  - LD_WAIT: on v_rvalid, buf[k]=v_rdata. If k+1==len go to RD_ISSUE; else k++ and go to LD_ISSUE.
  - RD_ISSUE: c_rd_en=1, c_rd_row=i, c_rd_col=j, go to RD_WAIT.
  - RD_WAIT: on c_rd_rvalid, add_req=1, add_a=c_rd_rdata, add_b=buf[mode?i:j], go to ADD_WAIT.
  - ADD_WAIT: on add_rvalid, y_we=1, y_row=i, y_col=j, y_wdata=add_res.
    - If i==M-1 and j==N-1, go to FINISH.
    - Else if j==N-1, set j=0, i++, go to RD_ISSUE.
    - Else j++, go to RD_ISSUE.
  - FINISH: done=1, busy=0, go to IDLE.
- No minimum response latency is assumed. rvalid or add_rvalid pulses arriving outside the matching wait state are ignored.
- Exactly one transaction is outstanding at any time.
- start while not in IDLE is ignored. Mode changes mid-run have no effect.
- Index counters never wrap past M-1 or N-1. k never exceeds len-1.
- Reset mid-operation: synchronous abort to the reset state, with no further pulses.
- Minimum run time with 1-cycle responses: 2·len + 3·M·N + 2 cycles from start to done.

Test Plan:
- M=N=4, mode=0, V={1.0,2.0,3.0,4.0} (3F800000, 40000000, 40400000, 40800000), C all 1.0, 1-cycle SRAM and adder models -> 16 y_we pulses in row-major order. y[i][j]=1.0+V[j], e.g. y[2][1]=40400000. Exactly one done pulse. busy low afterwards.
- Same matrix, mode=1, V indexed by row -> y[i][j]=1.0+V[i]. Rows 3 all 40A00000.
- start with vec_valid=0 -> no v_rd_en, c_rd_en, add_req or y_we. err=1. done pulse 2 cycles after start. The next valid start clears err.
- Random 0–5 cycle delays on v_rvalid, c_rd_rvalid and add_rvalid, plus spurious add_rvalid during RD_WAIT -> results identical to the zero-delay run. Spurious pulses cause no writes.
- start re-pulsed while busy, and mode toggled mid-run -> ignored. Exactly 16 writes with the original mode.
- rst asserted after the 5th y_we -> next cycle busy=0, all pulses 0, state IDLE. A fresh start completes a full run correctly.
